// File: rtl/mc68040_bus_initiator.sv
// MC68040-protocol bus master: one client request becomes one 040 bus cycle, with retry, timeout and error status.
// Optional `INIT_LINE_BURST_EN enables 4-beat line transfers for SIZ=11.
module mc68040_bus_initiator #(
    parameter int TIMEOUT_CLKS = 128,
    parameter int RETRY_MAX    = 3
) (
    input  logic        clk40,
    input  logic        reset_n,
    input  logic        req,
    input  logic        req_rw,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_siz,
    input  logic [31:0] req_wdata,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata,
    output logic        br_n,
    input  logic        bg_n,
    input  logic        bb_n_in,
    output logic        bb_oe,
    output logic        ts_n,
    output logic        tip_n,
    output logic        bus_oe,
    output logic [31:0] a_out,
    output logic        rw_out,
    output logic [1:0]  siz_out,
    output logic [31:0] d_out,
    input  logic [31:0] d_in,
    input  logic        tack_n,
    input  logic        tea_n,
    input  logic        tbi_n
);

    // state | meaning
    // IDLE  | waiting for a client request
    // ARB   | bus requested, waiting for grant with bus not busy
    // START | TSn asserted for exactly one clock
    // WAIT  | transfer in progress, waiting for termination or timeout
    // RETRY | one idle clock holding the bus before restarting
    // DONE  | ACK pulse, bus released
    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_START, S_WAIT, S_RETRY, S_DONE
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam int RW = $clog2(RETRY_MAX + 2);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);

    state_t        state, state_nx;
    logic [31:0]   addr_q, wdata_q, rdata_q;
    logic          rw_q, err_q;
    logic [1:0]    siz_q, beat;
    logic [TW-1:0] tmo_cnt;
    logic [RW-1:0] retry_cnt;
    logic          more_beats, capture, to_err, beat_adv;
    logic [1:0]    siz_lat;

`ifdef INIT_LINE_BURST_EN
    // A TBIn on the first beat turns a line into a single transfer.
    assign more_beats = (siz_q == 2'b11) && (beat != 2'd3) && !((beat == 2'd0) && !tbi_n);
    assign siz_lat    = req_siz;
`else
    logic unused_tbi;
    assign unused_tbi = tbi_n;
    assign more_beats = 1'b0;
    assign siz_lat    = (req_siz == 2'b11) ? 2'b00 : req_siz;
`endif

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        to_err   = 1'b0;
        beat_adv = 1'b0;
        case (state)
            S_IDLE:  if (req) state_nx = S_ARB;
            S_ARB:   if (!bg_n && bb_n_in) state_nx = S_START;
            S_START: state_nx = S_WAIT;
            S_WAIT: begin
                if (!tack_n && !tea_n) begin
                    state_nx = S_RETRY;
                end else if (!tea_n) begin
                    state_nx = S_DONE;
                    to_err   = 1'b1;
                end else if (!tack_n) begin
                    capture = rw_q;
                    if (more_beats) beat_adv = 1'b1;
                    else            state_nx = S_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nx = S_DONE;
                    to_err   = 1'b1;
                end
            end
            S_RETRY: begin
                if (retry_cnt > RETRY_LIM) begin
                    state_nx = S_DONE;
                    to_err   = 1'b1;
                end else begin
                    state_nx = S_START;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk40 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rw_q      <= 1'b0;
            err_q     <= 1'b0;
            siz_q     <= '0;
            beat      <= '0;
            tmo_cnt   <= '0;
            retry_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && req) begin
                addr_q    <= req_addr;
                wdata_q   <= req_wdata;
                rw_q      <= req_rw;
                siz_q     <= siz_lat;
                err_q     <= 1'b0;
                retry_cnt <= '0;
                beat      <= '0;
            end
            if (state == S_START) begin
                tmo_cnt <= '0;
            end else if (state == S_WAIT) begin
                if (beat_adv) begin
                    tmo_cnt <= '0;
                    beat    <= beat + 2'd1;
                end else if (tmo_cnt != TMO_LAST) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
            // A restarted line begins again from its first beat.
            if (state == S_RETRY) beat <= '0;
            if (state == S_WAIT && state_nx == S_RETRY) retry_cnt <= retry_cnt + 1'b1;
            if (capture) rdata_q <= d_in;
            if (to_err)  err_q   <= 1'b1;
        end
    end

    assign ack     = (state == S_DONE);
    assign err     = (state == S_DONE) && err_q;
    assign rdata   = rdata_q;
    assign br_n    = (state != S_ARB);
    assign ts_n    = (state != S_START);
    assign tip_n   = !((state == S_START) || (state == S_WAIT));
    assign bb_oe   = (state == S_START) || (state == S_WAIT) || (state == S_RETRY);
    assign bus_oe  = bb_oe;
    assign a_out   = {addr_q[31:4], addr_q[3:2] + beat, addr_q[1:0]};
    assign rw_out  = rw_q;
    assign siz_out = siz_q;
    assign d_out   = wdata_q;

endmodule

// File: tb/tb_mc68040_bus_initiator.sv
// Self-checking bench for mc68040_bus_initiator: vector table plus hand-written retry/timeout/reset/line sequences.
module tb_mc68040_bus_initiator;
    localparam int TMO  = 128;
    localparam int RMAX = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, req_rw;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_siz;
    logic        ack, err;
    logic [31:0] rdata;
    logic        br_n, bg_n, bb_n_in, bb_oe, ts_n, tip_n, bus_oe;
    logic [31:0] a_out;
    logic        rw_out;
    logic [1:0]  siz_out;
    logic [31:0] d_out, d_in;
    logic        tack_n, tea_n, tbi_n;

    mc68040_bus_initiator #(.TIMEOUT_CLKS(TMO), .RETRY_MAX(RMAX)) dut (
        .clk40(clk), .reset_n(rst_n), .req(req), .req_rw(req_rw), .req_addr(req_addr),
        .req_siz(req_siz), .req_wdata(req_wdata), .ack(ack), .err(err), .rdata(rdata),
        .br_n(br_n), .bg_n(bg_n), .bb_n_in(bb_n_in), .bb_oe(bb_oe), .ts_n(ts_n),
        .tip_n(tip_n), .bus_oe(bus_oe), .a_out(a_out), .rw_out(rw_out), .siz_out(siz_out),
        .d_out(d_out), .d_in(d_in), .tack_n(tack_n), .tea_n(tea_n), .tbi_n(tbi_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [1:0]  siz;
        logic [31:0] wdata;
        int          wait_clks;
        int          term;       // 0 TACKn, 1 TEAn, 2 both (retry)
        logic [31:0] din;
        logic [1:0]  exp_siz;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[5];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_rd = 32'h0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic e, input logic [31:0] rd);
        exp_t x;
        x.err   = e;
        x.rdata = rd;
        sb.push_back(x);
    endtask

    task automatic request(input logic rw, input logic [31:0] addr, input logic [1:0] siz,
                           input logic [31:0] wd);
        req = 1'b1; req_rw = rw; req_addr = addr; req_siz = siz; req_wdata = wd;
        tick;
        req = 1'b0;
        req_rw = ~rw; req_addr = $urandom; req_siz = 2'($urandom); req_wdata = $urandom;
    endtask

    task automatic pulse_term(input int kind, input logic [31:0] din);
        tack_n = (kind == 1);
        tea_n  = (kind == 0);
        d_in   = din;
        tick;
        tack_n = 1'b1;
        tea_n  = 1'b1;
        d_in   = $urandom;
    endtask

    task automatic wait_ts(input string name, output bit ok);
        int n;
        n = 0;
        while (ts_n && n < 50) begin
            tick;
            n++;
        end
        ok = !ts_n;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: TSn never asserted", name);
        end
    endtask

    task automatic wait_ack(input string name);
        int   n;
        exp_t x;
        n = 0;
        while (!ack && n < 400) begin
            tick;
            n++;
        end
        if (!ack) begin
            checks++;
            errors++;
            $display("FAIL %s: no ACK within cycle budget", name);
            if (sb.size() > 0) x = sb.pop_front();
        end else if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: ACK with empty scoreboard", name);
        end else begin
            x = sb.pop_front();
            check({name, " err"}, 32'(err), 32'(x.err));
            check({name, " rdata"}, rdata, x.rdata);
            tick;
            check({name, " ack one clock"}, 32'(ack), 32'd0);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        bit          ok;
        logic        e;
        logic [31:0] rd;
        e  = (v.term != 0);
        rd = (v.rw && v.term == 0) ? v.din : last_rd;
        last_rd = rd;
        push_exp(e, rd);
        request(v.rw, v.addr, v.siz, v.wdata);
        check({name, " br_n in arb"}, 32'(br_n), 32'd0);
        wait_ts(name, ok);
        if (ok) begin
            check({name, " a_out"}, a_out, v.addr);
            check({name, " rw_out"}, 32'(rw_out), 32'(v.rw));
            check({name, " siz_out"}, 32'(siz_out), 32'(v.exp_siz));
            check({name, " start strobes"}, 32'({bus_oe, bb_oe, tip_n, br_n}), 32'b1101);
            if (!v.rw) check({name, " d_out"}, d_out, v.wdata);
        end
        tick;
        check({name, " ts one clock"}, 32'(ts_n), 32'd1);
        repeat (v.wait_clks) tick;
        pulse_term(v.term, v.din);
        check({name, " ack latency"}, 32'(ack), 32'd1);
        wait_ack(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          n, bad, pulses, extra;
        logic [1:0]  eb;

        vecs[0] = '{1'b1, 32'h00F80000, 2'b00, 32'h0,        2, 0, 32'h11144EF9, 2'b00};
        vecs[1] = '{1'b0, 32'h00002002, 2'b10, 32'hCAFEF00D, 0, 0, 32'h0,        2'b10};
        vecs[2] = '{1'b1, 32'h00000003, 2'b01, 32'h0,        1, 1, 32'h55AA55AA, 2'b01};
        vecs[3] = '{1'b1, 32'h00400010, 2'b00, 32'h0,        5, 0, 32'h87654321, 2'b00};
        vecs[4] = '{1'b0, 32'hFFFFFFFC, 2'b00, 32'h01234567, 3, 1, 32'h0,        2'b00};

        rst_n = 1'b0; req = 1'b0; req_rw = 1'b0; req_addr = '0; req_siz = '0; req_wdata = '0;
        bg_n = 1'b0; bb_n_in = 1'b1; tack_n = 1'b1; tea_n = 1'b1; tbi_n = 1'b1; d_in = '0;
        repeat (2) tick;
        check("reset strobes", 32'({br_n, ts_n, tip_n, bb_oe, bus_oe, ack, err}), 32'b1110000);
        check("reset rdata", rdata, 32'h0);
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Grant withheld for 5 clocks, then grant lost mid-transfer.
        push_exp(1'b0, last_rd);
        bg_n = 1'b1;
        request(1'b0, 32'h00001000, 2'b00, 32'hDEADBEEF);
        bad = 0;
        repeat (5) begin
            if (!ts_n || br_n) bad++;
            tick;
        end
        check("no ts before grant", 32'(bad), 32'd0);
        bg_n = 1'b0;
        tick;
        check("ts after grant", 32'(ts_n), 32'd0);
        check("write d_out", d_out, 32'hDEADBEEF);
        check("write bus_oe rw", 32'({bus_oe, rw_out}), 32'b10);
        tick;
        bg_n = 1'b1;
        tick;
        pulse_term(0, 32'h0);
        wait_ack("grant write");
        bg_n = 1'b0;

        // No responder: timeout.
        push_exp(1'b1, last_rd);
        request(1'b1, 32'h00F00000, 2'b00, 32'h0);
        wait_ts("timeout", ok);
        tick;
        n = 0;
        bad = 0;
        while (!ack && n < 300) begin
            tick;
            n++;
            if (!ts_n) bad++;
        end
        check("timeout clocks", 32'(n), 32'(TMO));
        wait_ack("timeout");
        repeat (3) begin
            if (!ts_n) bad++;
            tick;
        end
        check("timeout no ts", 32'(bad), 32'd0);

        // Retry four times: three restarts then error.
        push_exp(1'b1, last_rd);
        request(1'b1, 32'h00000100, 2'b00, 32'h0);
        pulses = 0;
        for (int r = 0; r <= RMAX; r++) begin
            wait_ts("retry", ok);
            if (ok) pulses++;
            tick;
            pulse_term(2, 32'h0);
            if (r == 0) check("retry state bus", 32'({tip_n, bus_oe, ts_n}), 32'b111);
        end
        n = 0;
        extra = 0;
        while (!ack && n < 400) begin
            tick;
            n++;
            if (!ts_n) extra++;
        end
        check("retry ts pulses", 32'(pulses + extra), 32'(RMAX + 1));
        check("retry final latency", 32'(n), 32'd1);
        wait_ack("retry");

        // Reset during WAIT.
        request(1'b1, 32'h00000200, 2'b00, 32'h0);
        wait_ts("reset", ok);
        tick;
        rst_n = 1'b0;
        #1;
        check("reset mid-cycle drivers", 32'({bus_oe, bb_oe, ts_n, tip_n, br_n}), 32'b00111);
        bad = 0;
        repeat (3) begin
            tick;
            if (ack) bad++;
        end
        check("reset no ack", 32'(bad), 32'd0);
        rst_n = 1'b1;
        last_rd = 32'h0;
        tick;
        run_vec(vecs[0], "post-reset");

`ifdef INIT_LINE_BURST_EN
        push_exp(1'b0, 32'hB0000003);
        request(1'b1, 32'h00000008, 2'b11, 32'h0);
        wait_ts("burst", ok);
        check("burst siz", 32'(siz_out), 32'd3);
        tick;
        bad = 0;
        for (int b = 0; b < 4; b++) begin
            eb = 2'(2 + b);
            check($sformatf("burst beat%0d addr", b), 32'(a_out[3:2]), 32'(eb));
            if (b == 1) repeat (2) tick;
            pulse_term(0, 32'hB0000000 + 32'(b));
            if (b < 3 && ack) bad++;
        end
        check("burst early ack", 32'(bad), 32'd0);
        wait_ack("burst");
        last_rd = 32'hB0000003;

        push_exp(1'b0, 32'h000000C1);
        request(1'b1, 32'h00000008, 2'b11, 32'h0);
        wait_ts("tbi", ok);
        tick;
        tbi_n = 1'b0;
        pulse_term(0, 32'h000000C1);
        tbi_n = 1'b1;
        check("tbi single beat ack", 32'(ack), 32'd1);
        wait_ack("tbi");
        last_rd = 32'h000000C1;
`else
        push_exp(1'b0, 32'h000000C1);
        request(1'b1, 32'h00000008, 2'b11, 32'h0);
        wait_ts("line as long", ok);
        check("line siz as long", 32'(siz_out), 32'd0);
        check("line addr", a_out, 32'h00000008);
        tick;
        tbi_n = 1'b0;
        pulse_term(0, 32'h000000C1);
        tbi_n = 1'b1;
        check("line single ack", 32'(ack), 32'd1);
        wait_ack("line as long");
        last_rd = 32'h000000C1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
